// File: rtl/nios2_nios2_0_cpu_debug_scan_master.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_nios2_0_cpu_debug_scan_master
//  Purpose  : Virtual-JTAG scan master for the Nios II debug slave. For each
//             accepted command it walks the virtual state sequence
//             UIR -> CDR -> SDR -> UDR. It presents cmd_ir on ir_in and
//             captures ir_out during UIR. It shifts cmd_dr out on tdi (LSB
//             first) while collecting tdo into the same shift register, then
//             returns the captured word on the response channel.
//
//  Ports    : clk, reset          - system clock, synchronous active-high reset
//             cmd_valid/ready     - command handshake (accepted only in IDLE)
//             cmd_ir, cmd_dr      - virtual IR value and DR data for the scan
//             rsp_valid/ready     - response handshake (held until consumed)
//             rsp_dr, rsp_ir      - captured tdo word and sampled ir_out
//             tck, tdi, tdo       - free-running scan clock and serial data
//             ir_in, ir_out       - IR value to slave / IR status from slave
//             vs_uir..vs_udr      - virtual-state strobes
//             jtag_state_rti      - run-test-idle indicator
//
//  Revision : 1.0 - initial release
// ============================================================================
module nios2_nios2_0_cpu_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [1:0]          rsp_ir,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [1:0]          ir_in,
    input  logic [1:0]          ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_div_w = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int c_cnt_w = $clog2(DR_WIDTH + 1);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(TCK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_bits     = c_cnt_w'(DR_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UIR  = 3'd2,
        ST_CDR  = 3'd3,
        ST_SDR  = 3'd4,
        ST_UDR  = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

    // ------------------------------------------------------------------------
    // TCK generation
    // ------------------------------------------------------------------------
    logic [c_div_w-1:0] r_div;
    logic               r_tck;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;

    assign w_tick = (r_div == c_div_last);
    // Events are decoded from the current tck level: the toggle that is about
    // to happen on this clk edge is a rise if tck is currently low.
    assign w_rise = w_tick & ~r_tck;
    assign w_fall = w_tick &  r_tck;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (w_tick) begin
            r_div <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_div <= r_div + c_div_one;
        end
    end

    // ------------------------------------------------------------------------
    // Scan state and datapath registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [DR_WIDTH-1:0] r_sr;
    logic [c_cnt_w-1:0]  r_bitcnt;
    logic                r_tdi;
    logic [1:0]          r_ir_in;
    logic                r_vs_uir;
    logic                r_vs_cdr;
    logic                r_vs_sdr;
    logic                r_vs_udr;
    logic                r_rti;
    logic                r_rsp_valid;
    logic [DR_WIDTH-1:0] r_rsp_dr;
    logic [1:0]          r_rsp_ir;

    state_t              w_state_nxt;
    logic [DR_WIDTH-1:0] w_sr_nxt;
    logic [c_cnt_w-1:0]  w_bitcnt_nxt;
    logic                w_tdi_nxt;
    logic [1:0]          w_ir_in_nxt;
    logic                w_vs_uir_nxt;
    logic                w_vs_cdr_nxt;
    logic                w_vs_sdr_nxt;
    logic                w_vs_udr_nxt;
    logic                w_rti_nxt;
    logic                w_rsp_valid_nxt;
    logic [DR_WIDTH-1:0] w_rsp_dr_nxt;
    logic [1:0]          w_rsp_ir_nxt;

    // Shift register input: tdo enters at the MSB so that after DR_WIDTH
    // shifts the first captured bit has reached the LSB.
    logic [DR_WIDTH-1:0] w_sr_shift;

    generate
        if (DR_WIDTH > 1) begin : g_shift_multi
            assign w_sr_shift = {tdo, r_sr[DR_WIDTH-1:1]};
        end else begin : g_shift_single
            assign w_sr_shift = tdo;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_bitcnt_nxt    = r_bitcnt;
        w_tdi_nxt       = r_tdi;
        w_ir_in_nxt     = r_ir_in;
        w_vs_uir_nxt    = r_vs_uir;
        w_vs_cdr_nxt    = r_vs_cdr;
        w_vs_sdr_nxt    = r_vs_sdr;
        w_vs_udr_nxt    = r_vs_udr;
        w_rti_nxt       = r_rti;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dr_nxt    = r_rsp_dr;
        w_rsp_ir_nxt    = r_rsp_ir;

        case (r_state)
            ST_IDLE: begin
                // Acceptance is clk-synchronous; the scan itself waits for
                // the next fall event in LOAD.
                if (cmd_valid) begin
                    w_ir_in_nxt = cmd_ir;
                    w_sr_nxt    = cmd_dr;
                    w_state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (w_fall) begin
                    w_state_nxt  = ST_UIR;
                    w_vs_uir_nxt = 1'b1;
                    w_rti_nxt    = 1'b0;
                end
            end

            ST_UIR: begin
                if (w_rise) begin
                    w_rsp_ir_nxt = ir_out;
                end
                if (w_fall) begin
                    w_state_nxt  = ST_CDR;
                    w_vs_uir_nxt = 1'b0;
                    w_vs_cdr_nxt = 1'b1;
                end
            end

            ST_CDR: begin
                if (w_fall) begin
                    w_state_nxt  = ST_SDR;
                    w_vs_cdr_nxt = 1'b0;
                    w_vs_sdr_nxt = 1'b1;
                    w_tdi_nxt    = r_sr[0];
                end
            end

            ST_SDR: begin
                if (w_rise) begin
                    w_sr_nxt     = w_sr_shift;
                    w_bitcnt_nxt = r_bitcnt + c_cnt_one;
                end
                if (w_fall) begin
                    if (r_bitcnt < c_bits) begin
                        w_tdi_nxt = r_sr[0];
                    end else begin
                        // All bits have been sampled: close the shift.
                        w_state_nxt  = ST_UDR;
                        w_vs_sdr_nxt = 1'b0;
                        w_vs_udr_nxt = 1'b1;
                        w_bitcnt_nxt = '0;
                        w_tdi_nxt    = 1'b0;
                    end
                end
            end

            ST_UDR: begin
                if (w_fall) begin
                    w_state_nxt     = ST_RSP;
                    w_vs_udr_nxt    = 1'b0;
                    w_rti_nxt       = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_dr_nxt    = r_sr;
                end
            end

            ST_RSP: begin
                // Leaving RSP is clk-synchronous; cmd_ready stays low in this
                // cycle so a simultaneous cmd_valid waits for IDLE.
                if (rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_bitcnt    <= '0;
            r_tdi       <= 1'b0;
            r_ir_in     <= 2'b00;
            r_vs_uir    <= 1'b0;
            r_vs_cdr    <= 1'b0;
            r_vs_sdr    <= 1'b0;
            r_vs_udr    <= 1'b0;
            r_rti       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dr    <= '0;
            r_rsp_ir    <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_tdi       <= w_tdi_nxt;
            r_ir_in     <= w_ir_in_nxt;
            r_vs_uir    <= w_vs_uir_nxt;
            r_vs_cdr    <= w_vs_cdr_nxt;
            r_vs_sdr    <= w_vs_sdr_nxt;
            r_vs_udr    <= w_vs_udr_nxt;
            r_rti       <= w_rti_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dr    <= w_rsp_dr_nxt;
            r_rsp_ir    <= w_rsp_ir_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_ready      = (r_state == ST_IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_dr         = r_rsp_dr;
    assign rsp_ir         = r_rsp_ir;
    assign tck            = r_tck;
    assign tdi            = r_tdi;
    assign ir_in          = r_ir_in;
    assign vs_uir         = r_vs_uir;
    assign vs_cdr         = r_vs_cdr;
    assign vs_sdr         = r_vs_sdr;
    assign vs_udr         = r_vs_udr;
    assign jtag_state_rti = r_rti;

endmodule
`default_nettype wire
